// File: rtl/rob_commit_queue.sv
// In-order retirement queue: dispatch allocates at tail, the CDB marks entries done,
// and the head retires one entry per cycle onto the register-file write port.
module rob_commit_queue #(
  parameter int ROB_DEPTH = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             issue_valid,
  input  logic             issue_has_rd,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  output logic [IDX_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic [IDX_W-1:0] query_tag,
  output logic             query_ready,
  output logic [31:0]      query_value,
  output logic             to_reg_we,
  output logic [4:0]       to_reg_rd,
  output logic [31:0]      to_reg_wdata,
  output logic             rob_empty
);

  logic [ROB_DEPTH-1:0] busy_reg, busy_next;
  logic [ROB_DEPTH-1:0] done_reg, done_next;
  logic [ROB_DEPTH-1:0] has_rd_reg;
  logic [4:0]           rd_reg    [ROB_DEPTH];
  logic [31:0]          value_reg [ROB_DEPTH];

  logic [IDX_W-1:0] head_reg, tail_reg;
  logic [IDX_W:0]   count_reg;

  logic                 issue_fire, commit_fire;
  logic [ROB_DEPTH-1:0] issue_hit, cdb_hit, commit_hit;

  // Depth is a power of two, so "not full" is simply the count MSB being clear.
  assign issue_ready = ~count_reg[IDX_W];
  assign issue_tag   = tail_reg;
  assign rob_empty   = (count_reg == '0);
  assign issue_fire  = issue_valid && issue_ready;
  assign commit_fire = busy_reg[head_reg] && done_reg[head_reg];
  assign query_ready = busy_reg[query_tag] && done_reg[query_tag];
  assign query_value = value_reg[query_tag];

  genvar gi;
  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      assign issue_hit[gi]  = issue_fire && (tail_reg == IDX_W'(gi));
      assign cdb_hit[gi]    = cdb_valid && (cdb_tag == IDX_W'(gi)) && busy_reg[gi] && !done_reg[gi];
      assign commit_hit[gi] = commit_fire && (head_reg == IDX_W'(gi));
    end
  endgenerate

  // Issue only targets a free slot, commit only a done one and the CDB only a not-done
  // busy one, so the three per-entry updates never collide.
  always_comb begin
    busy_next = busy_reg;
    done_next = done_reg;
    if (flush_in) begin
      busy_next = '0;
      done_next = '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (issue_hit[i]) begin
          busy_next[i] = 1'b1;
          done_next[i] = 1'b0;
        end
        if (commit_hit[i]) busy_next[i] = 1'b0;
        if (cdb_hit[i])    done_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_reg <= '0;
      done_reg <= '0;
    end else if (rdy_in) begin
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (issue_hit[i]) begin
          has_rd_reg[i] <= issue_has_rd;
          rd_reg[i]     <= issue_rd;
        end
        if (cdb_hit[i]) value_reg[i] <= cdb_value;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      to_reg_we    <= 1'b0;
      to_reg_rd    <= 5'd0;
      to_reg_wdata <= 32'd0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        to_reg_we <= 1'b0;
      end else begin
        if (issue_fire)  tail_reg <= tail_reg + IDX_W'(1);
        if (commit_fire) head_reg <= head_reg + IDX_W'(1);
        count_reg <= count_reg + {{IDX_W{1'b0}}, issue_fire} - {{IDX_W{1'b0}}, commit_fire};
        if (commit_fire) begin
          to_reg_we    <= has_rd_reg[head_reg] && (rd_reg[head_reg] != 5'd0);
          to_reg_rd    <= rd_reg[head_reg];
          to_reg_wdata <= value_reg[head_reg];
        end else begin
          to_reg_we    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue: hand-computed expectations for in-order retire,
// full/wrap, rd=0 suppression, flush and rdy_in freeze.
module tb_rob_commit_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        issue_valid;
  logic        issue_has_rd;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [2:0]  query_tag;
  logic        query_ready;
  logic [31:0] query_value;
  logic        to_reg_we;
  logic [4:0]  to_reg_rd;
  logic [31:0] to_reg_wdata;
  logic        rob_empty;

  int check_cnt = 0;
  int pass_cnt  = 0;

  rob_commit_queue #(.ROB_DEPTH(8), .IDX_W(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .issue_valid  (issue_valid),
    .issue_has_rd (issue_has_rd),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .issue_tag    (issue_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .query_tag    (query_tag),
    .query_ready  (query_ready),
    .query_value  (query_value),
    .to_reg_we    (to_reg_we),
    .to_reg_rd    (to_reg_rd),
    .to_reg_wdata (to_reg_wdata),
    .rob_empty    (rob_empty)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-18s got=%h", tag, got);
    end else begin
      $display("FAIL %-18s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are read there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    flush_in = 0; issue_valid = 0; issue_has_rd = 0; issue_rd = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
  endtask

  task automatic pulse_reset();
    rst_in = 1; #1; rst_in = 0; #1;
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd);
    issue_valid = 1; issue_has_rd = has_rd; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
    tick();
    cdb_valid = 0;
  endtask

  task automatic query(input logic [2:0] tag);
    query_tag = tag; #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1; rdy_in = 1; query_tag = 0;
    idle_inputs();
    #2;
    check("rst issue_ready", 32'(issue_ready), 1);
    check("rst issue_tag", 32'(issue_tag), 0);
    check("rst rob_empty", 32'(rob_empty), 1);
    check("rst query_ready", 32'(query_ready), 0);
    check("rst to_reg_we", 32'(to_reg_we), 0);
    check("rst to_reg_wdata", to_reg_wdata, 0);
    rst_in = 0;

    // Single instruction: issue, complete, retire.
    issue(1, 5);
    check("s1 tag after iss", 32'(issue_tag), 1);
    check("s1 empty after iss", 32'(rob_empty), 0);
    cdb(0, 32'h1234);
    query(0);
    check("s1 query_ready", 32'(query_ready), 1);
    check("s1 query_value", query_value, 32'h1234);
    check("s1 we before", 32'(to_reg_we), 0);
    tick();
    check("s1 we", 32'(to_reg_we), 1);
    check("s1 rd", 32'(to_reg_rd), 5);
    check("s1 wdata", to_reg_wdata, 32'h1234);
    check("s1 empty", 32'(rob_empty), 1);
    tick();
    check("s1 we pulse", 32'(to_reg_we), 0);

    // Out-of-order completion retires in order.
    pulse_reset();
    check("s2 tag0", 32'(issue_tag), 0);
    issue(1, 1);
    check("s2 tag1", 32'(issue_tag), 1);
    issue(1, 2);
    check("s2 tag2", 32'(issue_tag), 2);
    issue(1, 3);
    cdb(2, 32'h30);
    check("s2 we after t2", 32'(to_reg_we), 0);
    cdb(0, 32'h10);
    check("s2 we after t0", 32'(to_reg_we), 0);
    cdb(1, 32'h20);
    check("s2 w1 we", 32'(to_reg_we), 1);
    check("s2 w1 rd", 32'(to_reg_rd), 1);
    check("s2 w1 data", to_reg_wdata, 32'h10);
    tick();
    check("s2 w2 we", 32'(to_reg_we), 1);
    check("s2 w2 rd", 32'(to_reg_rd), 2);
    check("s2 w2 data", to_reg_wdata, 32'h20);
    tick();
    check("s2 w3 we", 32'(to_reg_we), 1);
    check("s2 w3 rd", 32'(to_reg_rd), 3);
    check("s2 w3 data", to_reg_wdata, 32'h30);
    tick();
    check("s2 we end", 32'(to_reg_we), 0);
    check("s2 empty", 32'(rob_empty), 1);

    // Fill to full, reject a 9th, commit, refuse issue on the commit edge, then wrap.
    pulse_reset();
    for (int i = 0; i < 8; i++) issue(1, 5'(i + 1));
    check("s3 full ready", 32'(issue_ready), 0);
    check("s3 full tag", 32'(issue_tag), 0);
    issue(1, 5'd20);
    check("s3 9th tag", 32'(issue_tag), 0);
    check("s3 9th ready", 32'(issue_ready), 0);
    query(0);
    check("s3 t0 not done", 32'(query_ready), 0);
    cdb(0, 32'h100);
    check("s3 ready pre-cmt", 32'(issue_ready), 0);
    issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd21;
    tick();
    check("s3 cmt we", 32'(to_reg_we), 1);
    check("s3 cmt rd", 32'(to_reg_rd), 1);
    check("s3 cmt data", to_reg_wdata, 32'h100);
    check("s3 ready post", 32'(issue_ready), 1);
    check("s3 no credit tag", 32'(issue_tag), 0);
    tick();
    issue_valid = 0;
    check("s3 wrap tag", 32'(issue_tag), 1);
    check("s3 full again", 32'(issue_ready), 0);

    // rd=0 and no-rd instructions retire silently.
    pulse_reset();
    issue(1, 0);
    issue(0, 7);
    cdb(0, 32'hDEAD);
    check("s4 we a", 32'(to_reg_we), 0);
    cdb(1, 32'hBEEF);
    check("s4 we b", 32'(to_reg_we), 0);
    check("s4 rd0 data", to_reg_wdata, 32'hDEAD);
    tick();
    check("s4 we c", 32'(to_reg_we), 0);
    check("s4 nord data", to_reg_wdata, 32'hBEEF);
    check("s4 nord rd", 32'(to_reg_rd), 7);
    tick();
    check("s4 we d", 32'(to_reg_we), 0);
    check("s4 empty", 32'(rob_empty), 1);
    check("s4 head+2 tag", 32'(issue_tag), 2);

    // Flush discards everything, including same-cycle issue and CDB.
    pulse_reset();
    for (int i = 0; i < 4; i++) issue(1, 5'(i + 1));
    cdb(1, 32'h11);
    cdb(2, 32'h22);
    query(1);
    check("s5 pre query", 32'(query_ready), 1);
    flush_in = 1; issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd9;
    cdb_valid = 1; cdb_tag = 3; cdb_value = 32'h33;
    tick();
    idle_inputs();
    check("s5 empty", 32'(rob_empty), 1);
    check("s5 tag", 32'(issue_tag), 0);
    check("s5 ready", 32'(issue_ready), 1);
    check("s5 we", 32'(to_reg_we), 0);
    query(1);
    check("s5 q1 cleared", 32'(query_ready), 0);
    cdb(1, 32'h99);
    query(1);
    check("s5 stale cdb", 32'(query_ready), 0);
    check("s5 empty after", 32'(rob_empty), 1);
    tick();
    check("s5 we after", 32'(to_reg_we), 0);

    // rdy_in low freezes state and holds a pending write.
    pulse_reset();
    issue(1, 9);
    issue(1, 10);
    cdb(0, 32'h55);
    tick();
    check("s6 we", 32'(to_reg_we), 1);
    check("s6 rd", 32'(to_reg_rd), 9);
    rdy_in = 0;
    cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h66;
    issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd11;
    for (int i = 0; i < 3; i++) begin
      tick();
      query(1);
      check("s6 frz we", 32'(to_reg_we), 1);
      check("s6 frz data", to_reg_wdata, 32'h55);
      check("s6 frz q1", 32'(query_ready), 0);
      check("s6 frz tag", 32'(issue_tag), 2);
    end
    issue_valid = 0;
    rdy_in = 1;
    tick();
    cdb_valid = 0;
    query(1);
    check("s6 thaw we", 32'(to_reg_we), 0);
    check("s6 thaw q1", 32'(query_ready), 1);
    check("s6 thaw qval", query_value, 32'h66);
    tick();
    check("s6 w2 we", 32'(to_reg_we), 1);
    check("s6 w2 rd", 32'(to_reg_rd), 10);
    check("s6 w2 data", to_reg_wdata, 32'h66);
    check("s6 empty", 32'(rob_empty), 1);
    rst_in = 1; #1;
    check("s6 async we drop", 32'(to_reg_we), 0);
    check("s6 async wdata", to_reg_wdata, 0);
    rst_in = 0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rob_commit_queue.md
Name: rob_commit_queue

Overview:
- In-order retirement queue (reorder buffer core) for the out-of-order RV32I core.
- Dispatch allocates entries in program order, and the common data bus (CDB) marks them done with a value.
- The head entry retires in order and drives the register-file write port (write enable, rd, wdata); it is the producer side of that port.
- Also provides a combinational tag lookup so reservation stations can forward completed but uncommitted values.

Parameters:
- ROB_DEPTH, 8, number of entries (power of two).
- IDX_W, 3, tag width, log2(ROB_DEPTH).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; low freezes all state.
- flush_in  input  1  misprediction flush, discards all entries.
- issue_valid  input  1  allocate one entry this cycle.
- issue_has_rd  input  1  instruction writes a destination register.
- issue_rd  input  5  destination register index.
- issue_ready  output  1  queue can accept an allocation (count < ROB_DEPTH).
- issue_tag  output  IDX_W  tag given to the allocation this cycle (equals tail).
- cdb_valid  input  1  result broadcast.
- cdb_tag  input  IDX_W  entry being completed.
- cdb_value  input  32  result value.
- query_tag  input  IDX_W  lookup tag.
- query_ready  output  1  entry query_tag is allocated and done.
- query_value  output  32  value of entry query_tag.
- to_reg_we  output  1  register-file write enable.
- to_reg_rd  output  5  register-file write index.
- to_reg_wdata  output  32  register-file write data.
- rob_empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer. Each entry holds busy, done, has_rd, rd[4:0] and value[31:0]. Control is head, tail (IDX_W bits, wrap modulo ROB_DEPTH) and count (IDX_W+1 bits).
- Reset (async, rst_in high): all entries have busy=0 and done=0; head=tail=count=0; to_reg_we=0, to_reg_rd=0, to_reg_wdata=0. Combinational outputs follow: issue_ready=1, issue_tag=0, rob_empty=1, query_ready=0.
- rdy_in low: no state or registered output changes. Registered outputs hold their values, and the register file ignores them while rdy_in is low.
- Priority on each rising edge with rdy_in high: flush > (commit, CDB, issue). Commit, CDB and issue act concurrently.
- Flush: every entry gets busy=0 and done=0; head=tail=count=0; to_reg_we<=0. Same-cycle issue, CDB and commit are discarded.
- Issue: acts only if issue_valid && issue_ready.
  - Entry[tail] gets busy=1, done=0, has_rd, rd.
  - tail<=tail+1 (wraps from ROB_DEPTH-1 to 0).
  - If issue_valid is asserted while issue_ready=0, it is ignored with no error.
- issue_ready = count < ROB_DEPTH. There is no same-cycle credit from a commit, so a full queue that commits this cycle still refuses issue this cycle.
- CDB: if cdb_valid && entry[cdb_tag].busy && !done, the entry gets done=1 and value=cdb_value. A CDB to a non-busy entry, or to an entry already done, is ignored.
- Commit: when entry[head] has busy=1 and done=1 at the start of the edge:
  - entry[head].busy<=0 and head<=head+1.
  - to_reg_we<=has_rd && rd!=0; to_reg_rd<=rd; to_reg_wdata<=value.
  - Otherwise to_reg_we<=0, so to_reg_we is a one-cycle pulse per retired instruction.
  - Retired entries with rd=0 or without rd still retire but keep to_reg_we low.
  - At most one commit per cycle.
- Latency:
  - A CDB completion captured at edge N makes the entry eligible at edge N+1. If it is the head, to_reg_we is high during the cycle after edge N+1.
  - Minimum issue-to-write is 3 edges (issue at E0, CDB at E1, commit at E2).
- count update: count <= count + issue_accepted − commit_fired. Simultaneous issue and commit leaves count unchanged.
- Query (combinational): query_ready = entry[query_tag].busy && done; query_value = entry[query_tag].value. The query does not see a CDB arriving in the same cycle.
- Reset mid-operation: asynchronous clear as above; a pending to_reg_we drops immediately.

Test Plan:
- Reset, then issue rd=5 (tag 0), CDB tag0=0x0000_1234 one cycle later -> next cycle to_reg_we=1, to_reg_rd=5, to_reg_wdata=0x1234 for exactly one cycle; rob_empty=1 afterwards.
- Issue rd=1,2,3 (tags 0,1,2); CDB in order tag2=0x30, tag0=0x10, tag1=0x20 -> writes occur in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles after tag1 completes.
- Fill 8 entries -> issue_ready=0; a 9th issue_valid is ignored (tail unchanged). Complete tag0 and commit -> issue_ready=1 in the following cycle. Next tag issued is 0 (wrap).
- Issue rd=0 with value 0xDEAD and a no-rd instruction -> both retire (head advances by 2) with to_reg_we never high.
- Issue 4 entries, complete 2 non-head entries, assert flush_in -> count=0, rob_empty=1, issue_tag=0, no register write. Stale CDB to tag1 afterwards is ignored.
- Hold rdy_in low for 3 cycles while a CDB is presented -> no state change. The completion lands only when rdy_in=1, and a pending to_reg_we stays held rather than repeating.
